alu_mdu: RTL and testbench

- Parametrised next-generation ALU for the single-cycle CPU SoC. It adds an iterative multiply/divide unit with HI/LO registers.
- Plain ALU ops stay combinational, with the same-cycle result and Zero flag.
- MULT/MULTU/DIV/DIVU run over WIDTH cycles under a start/busy/done handshake. The control unit stalls the PC while busy.
- Sits in the execute path between the register file/immediate mux and the writeback mux.

---
 rtl/alu_mdu_pkg.sv | 34 +++
 rtl/alu_mdu_md_iter.sv | 86 ++++++++
 rtl/alu_mdu.sv | 78 +++++++
 tb/tb_alu_mdu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared ALU op encoding and multiply/divide helpers for alu_mdu.
package alu_mdu_pkg;

   typedef enum logic [4:0] {
      ALU_NOP   = 5'd0,
      ALU_ADD   = 5'd1,
      ALU_SUB   = 5'd2,
      ALU_AND   = 5'd3,
      ALU_OR    = 5'd4,
      ALU_NOR   = 5'd5,
      ALU_SLT   = 5'd6,
      ALU_SLTU  = 5'd7,
      ALU_LUI   = 5'd8,
      ALU_SLL   = 5'd9,
      ALU_SRL   = 5'd10,
      ALU_XOR   = 5'd11,
      ALU_SRA   = 5'd12,
      ALU_MULT  = 5'd13,
      ALU_MULTU = 5'd14,
      ALU_DIV   = 5'd15,
      ALU_DIVU  = 5'd16,
      ALU_MFHI  = 5'd17,
      ALU_MFLO  = 5'd18,
      ALU_MTHI  = 5'd19,
      ALU_MTLO  = 5'd20
   } alu_op_e;

   localparam int unsigned CNT_RST = 0;

   function automatic logic is_md(alu_op_e op);
      return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
   endfunction

endpackage

// File: rtl/alu_mdu_md_iter.sv
// Iterative multiply/divide: one shift-add or restore-subtract step per cycle
// on operand magnitudes, with sign fix-up applied to the final step's result.
module md_iter
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  alu_op_e            op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               fin,
   output logic [2*WIDTH-1:0] res
);
   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   d;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic               is_div, neg_q, neg_r;
   logic               sgn, sa, sb;
   logic [WIDTH-1:0]   ma, mb, rh, ql;
   logic [WIDTH:0]     sum, rsh, diff;

   assign sgn = (op == ALU_MULT) || (op == ALU_DIV);
   assign sa  = sgn & a[WIDTH-1];
   assign sb  = sgn & b[WIDTH-1];
   assign ma  = sa ? -a : a;
   assign mb  = sb ? -b : b;
   assign fin = busy && (cnt == CW'(WIDTH-1));

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
      rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = rsh - {1'b0, d};
      if (!is_div)
         acc_n = {sum, acc[WIDTH-1:1]};
      else if (diff[WIDTH])
         acc_n = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_n = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      rh = acc_n[2*WIDTH-1:WIDTH];
      ql = acc_n[WIDTH-1:0];
      if (!is_div)
         res = neg_q ? -acc_n : acc_n;
      else
         res = {neg_r ? -rh : rh, neg_q ? -ql : ql};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= CW'(CNT_RST);
      end else begin
         done <= fin;
         if (go) begin
            busy <= 1'b1;
            cnt  <= CW'(CNT_RST);
         end else if (busy) begin
            busy <= !fin;
            cnt  <= fin ? CW'(CNT_RST) : cnt + CW'(1);
         end
      end
   end

   // Divide by zero leaves quotient all ones; the un-negated quotient and the
   // sign-restored remainder then reproduce {dividend, all ones} naturally.
   always_ff @(posedge clk) begin
      if (go) begin
         acc    <= {{WIDTH{1'b0}}, ma};
         d      <= mb;
         is_div <= (op == ALU_DIV) || (op == ALU_DIVU);
         neg_q  <= (sa ^ sb) & ~(((op == ALU_DIV) || (op == ALU_DIVU)) && (b == '0));
         neg_r  <= sa;
      end else if (busy) begin
         acc <= acc_n;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational ops plus HI/LO registers fed by md_iter.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   Shamt,
   input  logic [4:0]       ALUOp,
   input  logic             start,
   output logic [WIDTH-1:0] C,
   output logic             Zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   alu_op_e            op;
   logic               md_go, fin;
   logic [2*WIDTH-1:0] res;

   assign op    = alu_op_e'(ALUOp);
   assign md_go = start & ~busy & is_md(op);

   md_iter #(.WIDTH(WIDTH)) u_md (
      .clk  (clk),
      .rst  (rst),
      .go   (md_go),
      .op   (op),
      .a    (A),
      .b    (B),
      .busy (busy),
      .done (done),
      .fin  (fin),
      .res  (res)
   );

   // fin implies busy, so MTHI/MTLO can never collide with a result write
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (fin) begin
         {hi, lo} <= res;
      end else if (start && !busy) begin
         if (op == ALU_MTHI) hi <= A;
         if (op == ALU_MTLO) lo <= A;
      end
   end

   always_comb begin
      C = A;
      case (op)
         ALU_ADD:  C = A + B;
         ALU_SUB:  C = A - B;
         ALU_AND:  C = A & B;
         ALU_OR:   C = A | B;
         ALU_XOR:  C = A ^ B;
         ALU_NOR:  C = ~(A | B);
         ALU_SLT:  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         ALU_SLTU: C = {{(WIDTH-1){1'b0}}, A < B};
         ALU_LUI:  C = B << (WIDTH/2);
         ALU_SLL:  C = A << Shamt;
         ALU_SRL:  C = A >> Shamt;
         ALU_SRA:  C = $signed(A) >>> Shamt;
         ALU_MFHI: C = hi;
         ALU_MFLO: C = lo;
         default:  C = A;
      endcase
   end

   assign Zero = (C == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: comb-op vector table plus multi-cycle MD sequences.
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B, C, hi, lo;
   logic [4:0]  Shamt, ALUOp;
   logic        start, Zero, busy, done;

   logic [15:0] A16, B16, C16, hi16, lo16;
   logic [3:0]  sh16;
   logic [4:0]  op16;
   logic        st16, z16, busy16, done16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Shamt(Shamt), .ALUOp(ALUOp),
      .start(start), .C(C), .Zero(Zero), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   alu_mdu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .A(A16), .B(B16), .Shamt(sh16), .ALUOp(op16),
      .start(st16), .C(C16), .Zero(z16), .busy(busy16), .done(done16),
      .hi(hi16), .lo(lo16)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] c;
      logic        z;
   } vec_t;

   vec_t v[19];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts an MD op, scrambles operands, optionally injects a DIV start at
   // busy cycle inj, then waits (bounded) for done. Returns in the done cycle.
   task automatic md_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int inj);
      int n;
      logic [31:0] oh;
      oh = hi;
      A = a; B = b; ALUOp = op; start = 1'b1;
      tick;
      start = 1'b0;
      chk({nm, "_busy_start"}, 64'(busy), 64'd1);
      chk({nm, "_done_start"}, 64'(done), 64'd0);
      A = 32'hDEAD_BEEF; B = 32'h0000_0003; ALUOp = ALU_MFHI;
      #1;
      chk({nm, "_mfhi_busy"}, 64'(C), 64'(oh));
      n = 0;
      while (busy && n < 100) begin
         if (n == inj) begin
            ALUOp = ALU_DIV; A = 32'd9; B = 32'd4; start = 1'b1;
            tick;
            start = 1'b0; ALUOp = ALU_MFHI;
         end else begin
            tick;
         end
         n++;
      end
      chk({nm, "_cycles"}, 64'(n), 64'd32);
      chk({nm, "_done"}, 64'(done), 64'd1);
      chk({nm, "_hilo"}, {hi, lo}, exp);
   endtask

   initial begin
      int n, seen;

      v[0]  = '{ALU_ADD,  32'hFFFFFFF8, 32'd3, 5'd0,  32'hFFFFFFFB, 1'b0};
      v[1]  = '{ALU_SUB,  32'hFFFFFFF8, 32'd3, 5'd0,  32'hFFFFFFF5, 1'b0};
      v[2]  = '{ALU_SLT,  32'hFFFFFFF8, 32'd3, 5'd0,  32'd1,        1'b0};
      v[3]  = '{ALU_SLTU, 32'hFFFFFFF8, 32'd3, 5'd0,  32'd0,        1'b1};
      v[4]  = '{ALU_SRA,  32'hFFFFFFF8, 32'd3, 5'd1,  32'hFFFFFFFC, 1'b0};
      v[5]  = '{ALU_XOR,  32'hFFFFFFF8, 32'd3, 5'd0,  32'hFFFFFFFB, 1'b0};
      v[6]  = '{ALU_AND,  32'hFFFFFFF8, 32'd3, 5'd0,  32'd0,        1'b1};
      v[7]  = '{ALU_OR,   32'hFFFFFFF8, 32'd3, 5'd0,  32'hFFFFFFFB, 1'b0};
      v[8]  = '{ALU_NOR,  32'hFFFFFFF8, 32'd3, 5'd0,  32'd4,        1'b0};
      v[9]  = '{ALU_SUB,  32'd5,        32'd5, 5'd0,  32'd0,        1'b1};
      v[10] = '{ALU_LUI,  32'd0,  32'h1234,    5'd0,  32'h12340000, 1'b0};
      v[11] = '{ALU_SLL,  32'd1,        32'd0, 5'd31, 32'h80000000, 1'b0};
      v[12] = '{ALU_SRL,  32'h80000000, 32'd0, 5'd31, 32'd1,        1'b0};
      v[13] = '{ALU_SRA,  32'h80000000, 32'd0, 5'd31, 32'hFFFFFFFF, 1'b0};
      v[14] = '{ALU_NOP,  32'd0,        32'd7, 5'd0,  32'd0,        1'b1};
      v[15] = '{5'd31,    32'hABCD,     32'd7, 5'd0,  32'hABCD,     1'b0};
      v[16] = '{ALU_MULT, 32'h77,       32'd7, 5'd0,  32'h77,       1'b0};
      v[17] = '{ALU_SLT,  32'd3, 32'hFFFFFFF8, 5'd0,  32'd0,        1'b1};
      v[18] = '{ALU_SLTU, 32'd3, 32'hFFFFFFF8, 5'd0,  32'd1,        1'b0};

      rst = 1'b1; start = 1'b0; A = '0; B = '0; Shamt = '0; ALUOp = ALU_NOP;
      A16 = '0; B16 = '0; sh16 = '0; op16 = ALU_NOP; st16 = 1'b0;
      tick; tick;
      chk("rst_hi",   64'(hi),   64'd0);
      chk("rst_lo",   64'(lo),   64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      tick;

      foreach (v[i]) begin
         A = v[i].a; B = v[i].b; Shamt = v[i].sh; ALUOp = v[i].op;
         #1;
         chk($sformatf("comb%0d_c", i), 64'(C), 64'(v[i].c));
         chk($sformatf("comb%0d_z", i), 64'(Zero), 64'(v[i].z));
      end
      tick;

      md_op("mult",  ALU_MULT,  32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, -1);
      md_op("multu", ALU_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, -1);
      md_op("div",   ALU_DIV,   32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, -1);
      md_op("divu0", ALU_DIVU,  32'd7,        32'd0, 64'h00000007_FFFFFFFF, -1);
      md_op("divs0", ALU_DIV,   32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, -1);
      md_op("ovf",   ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, -1);
      md_op("ign",   ALU_MULT,  32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, 10);
      // started in the done cycle of the previous op
      md_op("chain", ALU_DIVU,  32'd9,        32'd4, 64'h00000001_00000002, -1);
      ALUOp = ALU_MFLO;
      #1;
      chk("chain_mflo", 64'(C), 64'd2);
      tick;

      // reset during busy cycle 5
      A = 32'd3; B = 32'd5; ALUOp = ALU_MULT; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_hilo", {hi, lo}, 64'd0);
      seen = 0;
      repeat (40) begin
         if (done) seen++;
         tick;
      end
      chk("mrst_nodone", 64'(seen), 64'd0);

      A = 32'h1234; ALUOp = ALU_MTHI; start = 1'b1;
      tick;
      start = 1'b0;
      chk("mthi_busy", 64'(busy), 64'd0);
      ALUOp = ALU_MFHI;
      #1;
      chk("mthi_mfhi", 64'(C), 64'h1234);
      A = 32'h55; ALUOp = ALU_MTLO; start = 1'b1;
      tick;
      start = 1'b0;
      chk("mtlo_hilo", {hi, lo}, 64'h00001234_00000055);
      chk("mt_nodone", 64'(done), 64'd0);

      A16 = 16'h7FFF; B16 = 16'h7FFF; op16 = ALU_MULT; st16 = 1'b1;
      tick;
      st16 = 1'b0; A16 = '0; B16 = '0;
      n = 0;
      while (busy16 && n < 100) begin
         tick;
         n++;
      end
      chk("w16_cycles", 64'(n), 64'd16);
      chk("w16_done", 64'(done16), 64'd1);
      chk("w16_hilo", 64'({hi16, lo16}), 64'h3FFF0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
